fdiv_tick_sched: RTL
====================

// Module: fdiv_tick_sched
// PURPOSE
//  Tick scheduler that owns the system-clock-to-1 kHz divider and shares it among N_CH timer channels.
//  - A prescaler derives a one-cycle tick (TICK_HZ) and a 50% square clk_out from clk_in.
//  - Each channel counts ticks down from a programmed period and raises an event on expiry.
//  - Events are serialised to one consumer through a round-robin valid/ready port.
//  - Sits between the clock-divider datapath and VGA-side consumers: blink, scroll, refresh timers.
// PARAMETERS
//  CLK_HZ   100_000_000  input clock frequency; CLK_HZ/TICK_HZ must be an even integer >= 4
//  TICK_HZ  1000         tick / clk_out frequency
//  N_CH     4            timer channels; power of 2, 2..16
//  PER_W    16           channel period width, in ticks
//  (localparams: DIV = CLK_HZ/TICK_HZ, CH_W = clog2(N_CH))
// PORTS
//  clk_in      in   1      system clock, all logic on rising edge
//  rst         in   1      synchronous reset, active high
//  cfg_valid   in   1      channel config request
//  cfg_ready   out  1      config accepted when cfg_valid & cfg_ready
//  cfg_ch      in   CH_W   channel index to configure
//  cfg_en      in   1      channel enable
//  cfg_period  in   PER_W  reload period in ticks
//  evt_valid   out  1      event available
//  evt_ready   in   1      consumer accepts event
//  evt_ch      out  CH_W   channel that expired
//  ovf         out  N_CH   sticky per-channel lost-event flag
//  tick        out  1      one-cycle pulse at TICK_HZ
//  clk_out     out  1      TICK_HZ square wave, 50% duty
// BEHAVIOUR
//  Reset (rst=1 at an edge): prescaler cnt=0, tick=0, clk_out=0, all en/period/count/pending/ovf=0,
//   evt_valid=0, evt_ch=0, RR pointer=0. Applies mid-operation too; prior state is discarded.
//  Prescaler:
//   - cnt runs 0..DIV-1, then wraps to 0.
//   - tick is registered: high for exactly the one cycle after the edge where cnt==DIV-1.
//   - First tick is in cycle DIV after reset release; then every DIV cycles.
//   - clk_out toggles on edges where cnt==DIV/2-1 or cnt==DIV-1.
//  Config:
//   - cfg_ready = ~tick, so no config is accepted in a tick cycle.
//   - On accept: period[ch] <= cfg_period, count[ch] <= cfg_period, ovf[ch] <= 0, pending[ch] <= 0.
//   - en[ch] <= cfg_en & (cfg_period!=0); a period of 0 disables the channel.
//  Countdown (only in cycles where tick=1), for each enabled channel:
//   - count==1: fire, count <= period.
//   - else: count <= count-1.
//   - Disabled channels hold their count.
//  Fire, at edge E: pending[ch] set at E. If pending[ch] was already set and is not being moved to the
//   output register at E, set ovf[ch] instead; the pending count stays 1.
//  Output stage:
//   - Loads when ~evt_valid | evt_ready.
//   - If any pending: evt_ch <= first pending channel, searching from RR pointer upward with wrap.
//     evt_valid <= 1, clear that pending bit, RR pointer <= evt_ch+1 (mod N_CH).
//   - Fire and load of the same channel at the same edge: the fire wins, so pending stays 1 and no ovf.
//   - No pending: evt_valid <= 0.
//   - While evt_valid & ~evt_ready, evt_ch is held stable.
//  Latency:
//   - Expiry evaluated in tick cycle T; pending visible T+1; evt_valid earliest T+2.
//   - Throughput: 1 event per cycle.
// TESTING (bench uses CLK_HZ=20, TICK_HZ=2, so DIV=10)
//  1. Release rst, then idle -> tick pulses at cycles 10, 20, 30; clk_out 5 cycles high / 5 low;
//     evt_valid stays 0.
//  2. cfg ch1 en=1 period=3, evt_ready=1 -> evt_valid with evt_ch=1, 2 cycles after every 3rd tick;
//     no other channel fires.
//  3. ch0, ch2, ch3 period=1, evt_ready=1 -> after each tick: evt_ch 0, 2, 3 on consecutive cycles;
//     same order on the next tick.
//  4. ch0 period=1, evt_ready=0 for 3 ticks -> evt_ch=0 held; ovf[0]=1 after the 3rd tick;
//     a cfg write to ch0 clears ovf[0].
//  5. cfg_valid in a tick cycle -> cfg_ready=0 that cycle and the request is accepted the next;
//     period=0 with en=1 -> channel never fires.
//  6. Assert rst while evt_valid=1 and pending!=0 -> evt_valid, ovf, tick, clk_out all 0 next cycle;
//     first tick again DIV cycles after release.

Source files
------------

// File: rtl/fdiv_tick_sched.sv
// Shared 1 kHz tick prescaler driving N_CH countdown timers whose
// expiry events are serialised round-robin onto one valid/ready port.
module fdiv_tick_sched #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1000,
   parameter int N_CH    = 4,
   parameter int PER_W   = 16,
   localparam int CH_W   = $clog2(N_CH)
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic             cfg_en,
   input  logic [PER_W-1:0] cfg_period,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [CH_W-1:0]  evt_ch,
   output logic [N_CH-1:0]  ovf,
   output logic             tick,
   output logic             clk_out
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int CNT_W = $clog2(DIV);

   logic [CNT_W-1:0] cnt;
   logic             wrap;
   logic             half;

   assign wrap = (cnt == CNT_W'(DIV - 1));
   assign half = (cnt == CNT_W'(DIV / 2 - 1));

   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt     <= '0;
         tick    <= 1'b0;
         clk_out <= 1'b0;
      end else begin
         cnt  <= wrap ? '0 : cnt + 1'b1;
         tick <= wrap;
         if (wrap || half)
            clk_out <= ~clk_out;
      end
   end

   // Config is refused in tick cycles so it never races the countdown.
   logic accept;

   assign cfg_ready = ~tick;
   assign accept    = cfg_valid & ~tick;

   logic [N_CH-1:0]  en;
   logic [N_CH-1:0]  pending;
   logic [N_CH-1:0]  fire;
   logic [N_CH-1:0]  take_vec;
   logic [PER_W-1:0] period [N_CH];
   logic [PER_W-1:0] count  [N_CH];

   always_comb begin
      fire = '0;
      for (int i = 0; i < N_CH; i++)
         fire[i] = tick & en[i] & (count[i] == PER_W'(1));
   end

   logic [CH_W-1:0] rr;
   logic [CH_W-1:0] sel;
   logic [CH_W-1:0] idx;
   logic            found;
   logic            load;
   logic            take;

   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = rr + CH_W'(k);
         if (!found && pending[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   assign load = ~evt_valid | evt_ready;
   assign take = load & found;

   always_comb begin
      take_vec = '0;
      if (take)
         take_vec[sel] = 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         en      <= '0;
         pending <= '0;
         ovf     <= '0;
         for (int i = 0; i < N_CH; i++) begin
            period[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (accept && cfg_ch == CH_W'(i)) begin
               period[i]  <= cfg_period;
               count[i]   <= cfg_period;
               ovf[i]     <= 1'b0;
               pending[i] <= 1'b0;
               en[i]      <= cfg_en & (cfg_period != '0);
            end else begin
               // A fire beats a same-edge load: the new event stays pending.
               if (fire[i]) begin
                  pending[i] <= 1'b1;
                  if (pending[i] && !take_vec[i])
                     ovf[i] <= 1'b1;
               end else if (take_vec[i]) begin
                  pending[i] <= 1'b0;
               end
               if (tick && en[i])
                  count[i] <= fire[i] ? period[i] : count[i] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         evt_valid <= 1'b0;
         evt_ch    <= '0;
         rr        <= '0;
      end else if (load) begin
         if (found) begin
            evt_valid <= 1'b1;
            evt_ch    <= sel;
            rr        <= sel + CH_W'(1);
         end else begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule
